// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types for the ibus/dbus memory port arbiter:
//   arb_state_t  - arbiter FSM states
//   MSIZE4       - size code used for every instruction fetch (4 bytes)
//   arb_req_t    - latched downstream request (addr/size/strobe/wdata)
//   streak_w()   - width of the dbus streak counter (never narrower than 3)
package mem_port_arbiter_pkg;

  localparam int MAX_ADDR_W = 64;

  // msize_t encoding is log2(bytes): 0=1B 1=2B 2=4B 3=8B
  localparam logic [2:0] MSIZE4 = 3'd2;

  typedef enum logic [2:0] {
    IDLE,
    REQ_I,
    WAIT_I,
    REQ_D,
    WAIT_D
  } arb_state_t;

  // addr is sized for the widest port; narrower ADDR_W uses the low bits
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [7:0]            strobe;
    logic [63:0]           wdata;
  } arb_req_t;

  function automatic int streak_w(input int max_streak);
    int w;
    w = $clog2(max_streak + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the ibus, dbus and downstream memory port signals.
//   master : the arbiter (serves ibus/dbus, drives the memory request)
//   slave  : the surroundings (core buses + memory responder)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64
);
  // ibus
  logic              i_valid;
  logic [ADDR_W-1:0] i_addr;
  logic              i_addr_ok;
  logic              i_data_ok;
  logic [31:0]       i_data;
  // dbus
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic [2:0]        d_size;
  logic [7:0]        d_strobe;
  logic [63:0]       d_wdata;
  logic              d_addr_ok;
  logic              d_data_ok;
  logic [63:0]       d_data;
  // downstream memory port
  logic              m_valid;
  logic [ADDR_W-1:0] m_addr;
  logic [2:0]        m_size;
  logic [7:0]        m_strobe;
  logic [63:0]       m_wdata;
  logic              m_ready;
  logic              m_resp_valid;
  logic [63:0]       m_rdata;

  modport master (
    input  i_valid, i_addr,
    output i_addr_ok, i_data_ok, i_data,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    output d_addr_ok, d_data_ok, d_data,
    output m_valid, m_addr, m_size, m_strobe, m_wdata,
    input  m_ready, m_resp_valid, m_rdata
  );

  modport slave (
    output i_valid, i_addr,
    input  i_addr_ok, i_data_ok, i_data,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  d_addr_ok, d_data_ok, d_data,
    input  m_valid, m_addr, m_size, m_strobe, m_wdata,
    output m_ready, m_resp_valid, m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_priority.sv
// arb_priority
// Combinational grant decision and streak update for the arbiter.
//   i_valid/d_valid : pending requests
//   streak          : consecutive dbus grants made while ibus was waiting
//   grant_i/grant_d : at most one set
//   streak_nxt      : value to load when the arbiter is in IDLE
module arb_priority #(
  parameter int MAX_DSTREAK = 4,
  parameter int STREAK_W    = 3
) (
  input  logic                i_valid,
  input  logic                d_valid,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_i,
  output logic                grant_d,
  output logic [STREAK_W-1:0] streak_nxt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DSTREAK);

  logic at_max;
  assign at_max = (streak == STREAK_MAX);

  always_comb begin
    // dbus wins unless ibus has already been passed over MAX_DSTREAK times
    grant_d    = d_valid & ~(i_valid & at_max);
    grant_i    = i_valid & ~grant_d;
    streak_nxt = streak;
    if (grant_d) begin
      // only count grants that actually made ibus wait
      if (i_valid) streak_nxt = at_max ? streak : streak + STREAK_W'(1);
      else         streak_nxt = '0;
    end else if (grant_i) begin
      streak_nxt = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-beat memory port between ibus and dbus. One requester
// is granted at a time from IDLE; its request is latched and presented
// downstream until accepted, then the arbiter waits for the response and
// returns it to that requester only.
//   clk   : clock
//   reset : asynchronous, active-low
//   bus   : ibus/dbus/memory signals (mem_port_arbiter_if.master)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int ADDR_W      = 64
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int STREAK_W = streak_w(MAX_DSTREAK);

  arb_state_t          state_q, state_d;
  arb_req_t            req_q, req_d;
  logic [STREAK_W-1:0] streak_q, streak_nxt;
  logic                grant_i, grant_d;

  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok, m_valid;
  logic [31:0] i_data;
  logic [63:0] d_data;

  arb_priority #(
    .MAX_DSTREAK(MAX_DSTREAK),
    .STREAK_W   (STREAK_W)
  ) u_prio (
    .i_valid   (bus.i_valid),
    .d_valid   (bus.d_valid),
    .streak    (streak_q),
    .grant_i   (grant_i),
    .grant_d   (grant_d),
    .streak_nxt(streak_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (state_q == IDLE) streak_q <= streak_nxt;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    m_valid   = 1'b0;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    i_data    = '0;
    d_data    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = REQ_D;
          req_d   = '{addr: MAX_ADDR_W'(bus.d_addr), size: bus.d_size,
                      strobe: bus.d_strobe, wdata: bus.d_wdata};
        end else if (grant_i) begin
          state_d = REQ_I;
          req_d   = '{addr: MAX_ADDR_W'(bus.i_addr), size: MSIZE4,
                      strobe: '0, wdata: '0};
        end
      end
      // a response arriving alongside m_ready is not ours yet; it is ignored
      REQ_I: begin
        m_valid = 1'b1;
        if (bus.m_ready) begin
          i_addr_ok = 1'b1;
          state_d   = WAIT_I;
        end
      end
      WAIT_I: begin
        if (bus.m_resp_valid) begin
          i_data_ok = 1'b1;
          i_data    = req_q.addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0];
          state_d   = IDLE;
        end
      end
      REQ_D: begin
        m_valid = 1'b1;
        if (bus.m_ready) begin
          d_addr_ok = 1'b1;
          state_d   = WAIT_D;
        end
      end
      WAIT_D: begin
        if (bus.m_resp_valid) begin
          d_data_ok = 1'b1;
          d_data    = bus.m_rdata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_valid   = m_valid;
  assign bus.m_addr    = req_q.addr[ADDR_W-1:0];
  assign bus.m_size    = req_q.size;
  assign bus.m_strobe  = req_q.strobe;
  assign bus.m_wdata   = req_q.wdata;
  assign bus.i_addr_ok = i_addr_ok;
  assign bus.i_data_ok = i_data_ok;
  assign bus.i_data    = i_data;
  assign bus.d_addr_ok = d_addr_ok;
  assign bus.d_data_ok = d_data_ok;
  assign bus.d_data    = d_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64)) bus ();

  mem_port_arbiter #(.MAX_DSTREAK(MAXD), .ADDR_W(64)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 ibus, 2 dbus; acc: downstream has accepted the request
  int          m_owner;
  bit          m_acc;
  int          m_streak;
  logic [63:0] l_addr, l_wdata;
  logic [2:0]  l_size;
  logic [7:0]  l_strb;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owner <= 0; m_acc <= 1'b0; m_streak <= 0;
      l_addr <= '0; l_wdata <= '0; l_size <= '0; l_strb <= '0;
    end else if (m_owner == 0) begin
      if (bus.d_valid && !(bus.i_valid && m_streak == MAXD)) begin
        m_owner  <= 2;
        l_addr   <= bus.d_addr; l_size <= bus.d_size;
        l_strb   <= bus.d_strobe; l_wdata <= bus.d_wdata;
        m_streak <= bus.i_valid ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
      end else if (bus.i_valid) begin
        m_owner  <= 1;
        l_addr   <= bus.i_addr; l_size <= 3'd2; l_strb <= '0; l_wdata <= '0;
        m_streak <= 0;
      end
    end else if (!m_acc) begin
      if (bus.m_ready) m_acc <= 1'b1;
    end else if (bus.m_resp_valid) begin
      m_owner <= 0;
      m_acc   <= 1'b0;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      automatic logic e_mv  = (m_owner != 0) && !m_acc;
      automatic logic e_iao = (m_owner == 1) && !m_acc && bus.m_ready;
      automatic logic e_dao = (m_owner == 2) && !m_acc && bus.m_ready;
      automatic logic e_ido = (m_owner == 1) && m_acc && bus.m_resp_valid;
      automatic logic e_ddo = (m_owner == 2) && m_acc && bus.m_resp_valid;
      automatic logic [31:0] e_id = !e_ido ? 32'h0 :
                                    (l_addr[2] ? bus.m_rdata[63:32] : bus.m_rdata[31:0]);
      automatic logic [63:0] e_dd = e_ddo ? bus.m_rdata : 64'h0;
      chk("m_valid",   64'(bus.m_valid),   64'(e_mv));
      chk("m_addr",    bus.m_addr,         l_addr);
      chk("m_size",    64'(bus.m_size),    64'(l_size));
      chk("m_strobe",  64'(bus.m_strobe),  64'(l_strb));
      chk("m_wdata",   bus.m_wdata,        l_wdata);
      chk("i_addr_ok", 64'(bus.i_addr_ok), 64'(e_iao));
      chk("d_addr_ok", 64'(bus.d_addr_ok), 64'(e_dao));
      chk("i_data_ok", 64'(bus.i_data_ok), 64'(e_ido));
      chk("d_data_ok", 64'(bus.d_data_ok), 64'(e_ddo));
      chk("i_data",    64'(bus.i_data),    64'(e_id));
      chk("d_data",    bus.d_data,         e_dd);
      chk("ok_onehot", 64'($countones({bus.i_addr_ok, bus.d_addr_ok,
                                       bus.i_data_ok, bus.d_data_ok}) <= 1), 64'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  function automatic logic any_ok();
    return bus.i_addr_ok | bus.d_addr_ok | bus.i_data_ok | bus.d_data_ok;
  endfunction

  initial begin
    logic [9:0] seq;
    int n;
    bus.i_valid = 0; bus.i_addr = '0;
    bus.d_valid = 0; bus.d_addr = '0; bus.d_size = '0; bus.d_strobe = '0; bus.d_wdata = '0;
    bus.m_ready = 0; bus.m_resp_valid = 0; bus.m_rdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cmp_en = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("idle_m_valid", 64'(bus.m_valid), 64'd0);
      chk("idle_ok", 64'(any_ok()), 64'd0);
      chk("idle_m_addr", bus.m_addr, 64'd0);
    end

    // single fetch, upper word
    tick(); bus.i_valid = 1; bus.i_addr = 64'h8000_0004;
    tick(); bus.m_ready = 1;
    sample();
    chk("f_addr_ok", 64'(bus.i_addr_ok), 64'd1);
    chk("f_m_addr", bus.m_addr, 64'h8000_0004);
    chk("f_m_size", 64'(bus.m_size), 64'd2);
    tick(); bus.m_ready = 0;
    sample();
    chk("f_wait_mvalid", 64'(bus.m_valid), 64'd0);
    tick(); bus.m_resp_valid = 1; bus.m_rdata = 64'h1111_2222_3333_4444;
    sample();
    chk("f_data_ok", 64'(bus.i_data_ok), 64'd1);
    chk("f_i_data", 64'(bus.i_data), 64'h1111_2222);
    tick(); bus.m_resp_valid = 0; bus.i_valid = 0;
    sample();
    chk("f_i_data_idle", 64'(bus.i_data), 64'd0);

    // dbus write beats simultaneous fetch, fetch follows (lower word)
    tick();
    bus.d_valid = 1; bus.d_addr = 64'h1000; bus.d_size = 3'd3;
    bus.d_strobe = 8'hFF; bus.d_wdata = 64'hDEAD_BEEF_0000_0001;
    bus.i_valid = 1; bus.i_addr = 64'h8000_0010; bus.m_ready = 1;
    tick();
    sample();
    chk("w_d_addr_ok", 64'(bus.d_addr_ok), 64'd1);
    chk("w_i_addr_ok", 64'(bus.i_addr_ok), 64'd0);
    chk("w_m_strobe", 64'(bus.m_strobe), 64'hFF);
    chk("w_m_wdata", bus.m_wdata, 64'hDEAD_BEEF_0000_0001);
    tick(); bus.m_resp_valid = 1; bus.m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    sample();
    chk("w_d_data_ok", 64'(bus.d_data_ok), 64'd1);
    chk("w_d_data", bus.d_data, 64'hAAAA_BBBB_CCCC_DDDD);
    tick(); bus.d_valid = 0; bus.m_resp_valid = 0;
    tick();
    sample();
    chk("w2_i_addr_ok", 64'(bus.i_addr_ok), 64'd1);
    chk("w2_m_strobe", 64'(bus.m_strobe), 64'd0);
    chk("w2_m_wdata", bus.m_wdata, 64'd0);
    tick(); bus.m_resp_valid = 1; bus.m_rdata = 64'h5555_6666_7777_8888;
    sample();
    chk("w2_i_data", 64'(bus.i_data), 64'h7777_8888);
    tick(); bus.i_valid = 0; bus.m_resp_valid = 0; bus.m_ready = 0;

    // starvation guard: both buses saturated, memory always ready/responding
    tick();
    bus.d_valid = 1; bus.d_addr = 64'h2000; bus.d_strobe = 8'h00; bus.d_size = 3'd3;
    bus.i_valid = 1; bus.i_addr = 64'h8000_0004;
    bus.m_ready = 1; bus.m_resp_valid = 1; bus.m_rdata = 64'h0123_4567_89AB_CDEF;
    seq = '0; n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      sample();
      if (bus.d_addr_ok)      begin seq[n] = 1'b1; n++; end
      else if (bus.i_addr_ok) begin seq[n] = 1'b0; n++; end
    end
    chk("grant_cnt", 64'(n), 64'd10);
    chk("grant_seq", 64'(seq), 64'(10'b01_1110_1111));
    tick(); bus.d_valid = 0; bus.i_valid = 0; bus.m_ready = 0; bus.m_resp_valid = 0;
    tick(); bus.m_resp_valid = 1;
    sample();
    chk("s_last_i_data_ok", 64'(bus.i_data_ok), 64'd1);
    tick(); bus.m_resp_valid = 0;

    // downstream stall in REQ_D
    tick();
    bus.d_valid = 1; bus.d_addr = 64'h3008; bus.d_size = 3'd1;
    bus.d_strobe = 8'h03; bus.d_wdata = 64'h55;
    tick();
    for (int k = 0; k < 20; k++) begin
      sample();
      chk("st_m_valid", 64'(bus.m_valid), 64'd1);
      chk("st_m_addr", bus.m_addr, 64'h3008);
      chk("st_ok", 64'(any_ok()), 64'd0);
    end
    tick(); bus.m_ready = 1;
    sample();
    chk("st_d_addr_ok", 64'(bus.d_addr_ok), 64'd1);
    tick(); bus.m_ready = 0; bus.m_resp_valid = 1; bus.m_rdata = 64'h00FF_00FF_00FF_00FF;
    sample();
    chk("st_d_data", bus.d_data, 64'h00FF_00FF_00FF_00FF);
    tick(); bus.d_valid = 0; bus.m_resp_valid = 0;

    // reset while waiting for an ibus response
    tick(); bus.i_valid = 1; bus.i_addr = 64'h8000_0008;
    tick(); bus.m_ready = 1;
    sample();
    chk("r_addr_ok", 64'(bus.i_addr_ok), 64'd1);
    tick(); bus.m_ready = 0;
    #2 reset = 1'b0; bus.i_valid = 0;
    #1;
    chk("r_m_addr", bus.m_addr, 64'd0);
    chk("r_m_valid", 64'(bus.m_valid), 64'd0);
    tick(); tick(); reset = 1'b1;
    tick(); bus.m_resp_valid = 1; bus.m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    sample();
    chk("r_no_data_ok", 64'(bus.i_data_ok), 64'd0);
    chk("r_i_data", 64'(bus.i_data), 64'd0);
    tick(); bus.m_resp_valid = 0;
    sample();
    chk("r_idle_m_valid", 64'(bus.m_valid), 64'd0);

    tick(); tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
